useq_engine: RTL and testbench

- Parametrised microcode sequencer. Replaces the fixed FETCH/DECODE/READ/EXEC phase ladder with a micro-PC (upc) and explicit next-address control.
- Drives the microcode ROM address and receives the sequencing slice of each microword.
- Generates the setup/M phase used to gate load strobes.
- Handles opcode dispatch, conditional micro-branches, micro-subroutines, break/continue, halt, fault and interrupt redirection.

---
 rtl/useq_pkg.sv | 25 ++
 rtl/useq_stack.sv | 58 +++++
 rtl/useq_engine.sv | 171 +++++++++++++++++
 tb/tb_useq_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/useq_pkg.sv
// Shared definitions for the microcode sequencer: seq_op encodings, run modes
// and the default vector addresses.
package useq_pkg;

    localparam logic [2:0] SEQ_NEXT     = 3'd0;
    localparam logic [2:0] SEQ_JUMP     = 3'd1;
    localparam logic [2:0] SEQ_DISPATCH = 3'd2;
    localparam logic [2:0] SEQ_BRANCH   = 3'd3;
    localparam logic [2:0] SEQ_CALL     = 3'd4;
    localparam logic [2:0] SEQ_RET      = 3'd5;
    localparam logic [2:0] SEQ_ENDI     = 3'd6;
    localparam logic [2:0] SEQ_BRK      = 3'd7;

    typedef enum logic [1:0] {
        ModeRun  = 2'd0,
        ModeHalt = 2'd1,
        ModeBrk  = 2'd2
    } mode_e;

    localparam int unsigned DEF_RESET_VEC = 0;
    localparam int unsigned DEF_FETCH_VEC = 2;
    localparam int unsigned DEF_IRQ_VEC   = 4;
    localparam int unsigned DEF_FAULT_VEC = 6;

endpackage

// File: rtl/useq_stack.sv
// Micro-return LIFO used by CALL/RET when the sequencer is built with USTACK_EN.
// Depth must be a power of two, at least 2.
module useq_stack #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [Width-1:0]         push_data_i,
    output logic [Width-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [CntW-1:0]  count_q, count_d;
    logic [PtrW-1:0]  top_idx;

    assign full_o     = (count_q == CntW'(Depth));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign top_idx    = count_q[PtrW-1:0] - PtrW'(1);
    assign pop_data_o = mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (push_i && !full_o) begin
            count_d = count_q + CntW'(1);
        end else if (pop_i && !empty_o) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage needs no reset; only count_q decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_i && !full_o && !clear_i) begin
            mem_q[count_q[PtrW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/useq_engine.sv
// Microcode sequencer: micro-PC with two-cycle (setup/M) microinstructions.
// Define USTACK_EN to build the micro-return stack; otherwise CALL=JUMP, RET=ENDI.
module useq_engine
    import useq_pkg::*;
#(
    parameter int unsigned UADDR_W     = 8,
    parameter int unsigned OPC_W       = 6,
    parameter int unsigned NFLAGS      = 8,
    parameter int unsigned RESET_VEC   = DEF_RESET_VEC,
    parameter int unsigned FETCH_VEC   = DEF_FETCH_VEC,
    parameter int unsigned IRQ_VEC     = DEF_IRQ_VEC,
    parameter int unsigned FAULT_VEC   = DEF_FAULT_VEC,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [OPC_W-1:0]               opcode,
    input  logic [2:0]                     seq_op,
    input  logic [UADDR_W-1:0]             seq_tgt,
    input  logic [$clog2(NFLAGS)-1:0]      cond_sel,
    input  logic [NFLAGS-1:0]              flags,
    input  logic                           irq_r,
    input  logic                           fault_r,
    input  logic                           halt_req,
    input  logic                           cont_r,
    output logic [UADDR_W-1:0]             uaddr,
    output logic                           phase_m,
    output logic                           halted,
    output logic                           in_break,
    output logic                           ustack_err,
    output logic [$clog2(STACK_DEPTH):0]   usp
);

    localparam logic [UADDR_W-1:0] ResetVec = UADDR_W'(RESET_VEC);
    localparam logic [UADDR_W-1:0] FetchVec = UADDR_W'(FETCH_VEC);
    localparam logic [UADDR_W-1:0] IrqVec   = UADDR_W'(IRQ_VEC);
    localparam logic [UADDR_W-1:0] FaultVec = UADDR_W'(FAULT_VEC);

    logic [UADDR_W-1:0]       upc_q, upc_d, upc_inc, endi_tgt;
    logic [UADDR_W+OPC_W-1:0] disp_sum;
    logic                     phase_q, phase_d;
    mode_e                    mode_q, mode_d;

    assign upc_inc  = upc_q + UADDR_W'(1);
    assign disp_sum = {{OPC_W{1'b0}}, seq_tgt} + {{UADDR_W{1'b0}}, opcode};
    assign endi_tgt = irq_r ? IrqVec : FetchVec;

`ifdef USTACK_EN
    logic               push, pop, clr, full, empty, err_q, err_d;
    logic [UADDR_W-1:0] pop_data;

    useq_stack #(
        .Depth (STACK_DEPTH),
        .Width (UADDR_W)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .clear_i     (clr),
        .push_data_i (upc_inc),
        .pop_data_o  (pop_data),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (usp)
    );

    assign ustack_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign usp        = '0;
    assign ustack_err = 1'b0;
`endif

    always_comb begin
        upc_d   = upc_q;
        phase_d = phase_q;
        mode_d  = mode_q;
`ifdef USTACK_EN
        push  = 1'b0;
        pop   = 1'b0;
        clr   = 1'b0;
        err_d = err_q;
`endif
        if (fault_r) begin
            // Fault aborts whatever phase we are in and empties the stack.
            upc_d   = FaultVec;
            phase_d = 1'b0;
            mode_d  = ModeRun;
`ifdef USTACK_EN
            clr = 1'b1;
`endif
        end else if (halt_req && mode_q == ModeRun) begin
            mode_d  = ModeHalt;
            phase_d = 1'b0;
        end else if (cont_r && mode_q == ModeBrk) begin
            mode_d  = ModeRun;
            upc_d   = FetchVec;
            phase_d = 1'b0;
        end else if (mode_q == ModeRun) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                unique case (seq_op)
                    SEQ_NEXT:     upc_d = upc_inc;
                    SEQ_JUMP:     upc_d = seq_tgt;
                    SEQ_DISPATCH: upc_d = disp_sum[UADDR_W-1:0];
                    SEQ_BRANCH:   upc_d = flags[cond_sel] ? seq_tgt : upc_inc;
                    SEQ_CALL: begin
`ifdef USTACK_EN
                        if (full) begin
                            err_d = 1'b1;
                            upc_d = FaultVec;
                            clr   = 1'b1;
                        end else begin
                            push  = 1'b1;
                            upc_d = seq_tgt;
                        end
`else
                        upc_d = seq_tgt;
`endif
                    end
                    SEQ_RET: begin
`ifdef USTACK_EN
                        if (empty) begin
                            err_d = 1'b1;
                            upc_d = FaultVec;
                            clr   = 1'b1;
                        end else begin
                            pop   = 1'b1;
                            upc_d = pop_data;
                        end
`else
                        upc_d = endi_tgt;
`endif
                    end
                    SEQ_ENDI:     upc_d = endi_tgt;
                    SEQ_BRK: begin
                        mode_d  = ModeBrk;
                        upc_d   = upc_inc;
                        phase_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upc_q   <= ResetVec;
            phase_q <= 1'b0;
            mode_q  <= ModeRun;
        end else begin
            upc_q   <= upc_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
        end
    end

    assign uaddr    = upc_q;
    assign phase_m  = phase_q;
    assign halted   = (mode_q == ModeHalt);
    assign in_break = (mode_q == ModeBrk);

endmodule

// File: tb/tb_useq_engine.sv
// Self-checking bench for useq_engine: table of microinstructions plus
// hand-written break/halt/fault/stack sequences, results via a scoreboard queue.
module tb_useq_engine;
    import useq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [2:0] seq_op;
    logic [7:0] seq_tgt;
    logic [5:0] seq_tgt6;
    logic [2:0] cond_sel;
    logic [7:0] flags;
    logic       irq_r, fault_r, halt_req, cont_r;

    logic [7:0] uaddr;
    logic       phase_m, halted, in_break, ustack_err;
    logic [2:0] usp;
    logic [5:0] uaddr6;
    logic       phase_m6, halted6, in_break6, ustack_err6;
    logic [2:0] usp6;

    assign seq_tgt6 = seq_tgt[5:0];

    always #5 clk = ~clk;

    useq_engine dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .seq_op     (seq_op),
        .seq_tgt    (seq_tgt),
        .cond_sel   (cond_sel),
        .flags      (flags),
        .irq_r      (irq_r),
        .fault_r    (fault_r),
        .halt_req   (halt_req),
        .cont_r     (cont_r),
        .uaddr      (uaddr),
        .phase_m    (phase_m),
        .halted     (halted),
        .in_break   (in_break),
        .ustack_err (ustack_err),
        .usp        (usp)
    );

    useq_engine #(.UADDR_W(6)) dut6 (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .seq_op     (seq_op),
        .seq_tgt    (seq_tgt6),
        .cond_sel   (cond_sel),
        .flags      (flags),
        .irq_r      (irq_r),
        .fault_r    (fault_r),
        .halt_req   (halt_req),
        .cont_r     (cont_r),
        .uaddr      (uaddr6),
        .phase_m    (phase_m6),
        .halted     (halted6),
        .in_break   (in_break6),
        .ustack_err (ustack_err6),
        .usp        (usp6)
    );

    typedef struct packed {
        logic [7:0] a8;
        logic [5:0] a6;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] tgt;
        logic [5:0] opc;
        logic [2:0] cs;
        logic [7:0] fl;
        logic       irq;
        logic [7:0] e8;
        logic [5:0] e6;
    } vec_t;

    exp_t       sb[$];
    vec_t       tbl[14];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] cur8;
    logic [5:0] cur6;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cur8  = 8'd0;
        cur6  = 6'd0;
    endtask

    // One full microinstruction: setup cycle, M cycle, then the next address.
    task automatic run_op(input logic [2:0] op, input logic [7:0] tgt, input logic [5:0] opc,
                          input logic [2:0] cs, input logic [7:0] fl, input logic irq,
                          input logic [7:0] e8, input logic [5:0] e6, input logic chk6,
                          input string name);
        exp_t e;
        seq_op   = op;
        seq_tgt  = tgt;
        opcode   = opc;
        cond_sel = cs;
        flags    = fl;
        irq_r    = irq;
        check({name, "_setup_phase"}, phase_m, 0);
        check({name, "_setup_addr"}, uaddr, cur8);
        sb.push_back('{a8: e8, a6: e6});
        tick();
        check({name, "_m_phase"}, phase_m, 1);
        check({name, "_m_addr"}, uaddr, cur8);
        tick();
        e = sb.pop_front();
        check({name, "_next"}, uaddr, e.a8);
        if (chk6) check({name, "_next6"}, uaddr6, e.a6);
        check({name, "_phase_after"}, phase_m, 0);
        cur8 = e.a8;
        cur6 = e.a6;
    endtask

    initial begin
        int bad;
        reset = 1'b0; opcode = '0; seq_op = SEQ_NEXT; seq_tgt = '0; cond_sel = '0;
        flags = '0; irq_r = 1'b0; fault_r = 1'b0; halt_req = 1'b0; cont_r = 1'b0;

        //         op            tgt    opc cs  flags  irq  e8     e6
        tbl[0]  = '{SEQ_NEXT,     8'h00, 0, 0, 8'h00, 0, 8'd1,   6'd1};
        tbl[1]  = '{SEQ_NEXT,     8'h00, 0, 0, 8'h00, 0, 8'd2,   6'd2};
        tbl[2]  = '{SEQ_NEXT,     8'h00, 0, 0, 8'h00, 0, 8'd3,   6'd3};
        tbl[3]  = '{SEQ_DISPATCH, 8'd64, 5, 0, 8'h00, 0, 8'd69,  6'd5};
        tbl[4]  = '{SEQ_DISPATCH, 8'd64, 63, 0, 8'h00, 0, 8'd127, 6'd63};
        tbl[5]  = '{SEQ_BRANCH,   8'h80, 0, 2, 8'h04, 0, 8'h80,  6'd0};
        tbl[6]  = '{SEQ_BRANCH,   8'h80, 0, 2, 8'h00, 0, 8'h81,  6'd1};
        tbl[7]  = '{SEQ_BRANCH,   8'h10, 0, 7, 8'h80, 0, 8'h10,  6'd16};
        tbl[8]  = '{SEQ_JUMP,     8'hFF, 0, 0, 8'h00, 0, 8'hFF,  6'd63};
        tbl[9]  = '{SEQ_NEXT,     8'h00, 0, 0, 8'h00, 0, 8'h00,  6'd0};
        tbl[10] = '{SEQ_ENDI,     8'h00, 0, 0, 8'h00, 0, 8'd2,   6'd2};
        tbl[11] = '{SEQ_ENDI,     8'h00, 0, 0, 8'h00, 1, 8'd4,   6'd4};
        tbl[12] = '{SEQ_BRANCH,   8'h40, 0, 2, 8'hFB, 0, 8'd5,   6'd5};
        tbl[13] = '{SEQ_JUMP,     8'h30, 0, 0, 8'h00, 0, 8'd48,  6'd48};

        do_reset();
        check("rst_uaddr", uaddr, 0);
        check("rst_phase", phase_m, 0);
        check("rst_halted", halted, 0);
        check("rst_break", in_break, 0);
        check("rst_err", ustack_err, 0);
        check("rst_usp", usp, 0);

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].op, tbl[i].tgt, tbl[i].opc, tbl[i].cs, tbl[i].fl, tbl[i].irq,
                   tbl[i].e8, tbl[i].e6, 1'b1, $sformatf("vec%0d", i));
        end

        // ENDI with irq and a fault arriving in the M cycle: fault wins.
        seq_op = SEQ_ENDI; irq_r = 1'b1;
        tick();
        fault_r = 1'b1;
        tick();
        fault_r = 1'b0; irq_r = 1'b0;
        check("endi_fault_addr", uaddr, 6);
        check("endi_fault_phase", phase_m, 0);
        cur8 = 8'd6;

        // BRK freezes at the following microword until cont_r.
        run_op(SEQ_BRK, 8'h00, 0, 0, 8'h00, 0, 8'd7, 6'd0, 1'b0, "brk");
        check("brk_in_break", in_break, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (uaddr !== 8'd7 || phase_m !== 1'b0 || in_break !== 1'b1) bad++;
        end
        check("brk_frozen", bad, 0);
        cont_r = 1'b1;
        tick();
        cont_r = 1'b0;
        check("cont_addr", uaddr, 2);
        check("cont_break", in_break, 0);
        check("cont_phase", phase_m, 0);
        cur8 = 8'd2;

        // cont_r is ignored while running.
        cont_r = 1'b1;
        run_op(SEQ_NEXT, 8'h00, 0, 0, 8'h00, 0, 8'd3, 6'd0, 1'b0, "cont_ignored");
        cont_r = 1'b0;

        // Fault during the setup cycle aborts mid-instruction.
        seq_op = SEQ_JUMP; seq_tgt = 8'h99; fault_r = 1'b1;
        tick();
        fault_r = 1'b0;
        check("fault_setup_addr", uaddr, 6);
        check("fault_setup_phase", phase_m, 0);
        cur8 = 8'd6;

        // Halt holds until reset; cont_r and seq ops have no effect.
        seq_op = SEQ_NEXT; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt_flag", halted, 1);
        check("halt_addr", uaddr, 6);
        seq_op = SEQ_JUMP; seq_tgt = 8'h55; cont_r = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (uaddr !== 8'd6 || phase_m !== 1'b0 || halted !== 1'b1) bad++;
        end
        cont_r = 1'b0;
        check("halt_frozen", bad, 0);
        do_reset();
        check("halt_rst_flag", halted, 0);
        check("halt_rst_addr", uaddr, 0);

`ifdef USTACK_EN
        run_op(SEQ_CALL, 8'h10, 0, 0, 8'h00, 0, 8'h10, 6'd0, 1'b0, "call1");
        run_op(SEQ_CALL, 8'h20, 0, 0, 8'h00, 0, 8'h20, 6'd0, 1'b0, "call2");
        run_op(SEQ_CALL, 8'h30, 0, 0, 8'h00, 0, 8'h30, 6'd0, 1'b0, "call3");
        run_op(SEQ_CALL, 8'h40, 0, 0, 8'h00, 0, 8'h40, 6'd0, 1'b0, "call4");
        check("usp_full", usp, 4);
        run_op(SEQ_RET, 8'h00, 0, 0, 8'h00, 0, 8'h31, 6'd0, 1'b0, "ret1");
        check("usp_3", usp, 3);
        run_op(SEQ_RET, 8'h00, 0, 0, 8'h00, 0, 8'h21, 6'd0, 1'b0, "ret2");
        run_op(SEQ_RET, 8'h00, 0, 0, 8'h00, 0, 8'h11, 6'd0, 1'b0, "ret3");
        run_op(SEQ_RET, 8'h00, 0, 0, 8'h00, 0, 8'h01, 6'd0, 1'b0, "ret4");
        check("usp_empty", usp, 0);
        check("err_clean", ustack_err, 0);
        for (int i = 0; i < 4; i++) begin
            run_op(SEQ_CALL, 8'h10 * (i + 1), 0, 0, 8'h00, 0, 8'h10 * (i + 1), 6'd0, 1'b0,
                   $sformatf("refill%0d", i));
        end
        run_op(SEQ_CALL, 8'h50, 0, 0, 8'h00, 0, 8'd6, 6'd0, 1'b0, "call_ovf");
        check("ovf_err", ustack_err, 1);
        check("ovf_usp", usp, 0);
        do_reset();
        check("err_rst", ustack_err, 0);
        run_op(SEQ_RET, 8'h00, 0, 0, 8'h00, 0, 8'd6, 6'd0, 1'b0, "ret_unf");
        check("unf_err", ustack_err, 1);
        check("unf_usp", usp, 0);
`else
        run_op(SEQ_CALL, 8'h20, 0, 0, 8'h00, 0, 8'h20, 6'd0, 1'b0, "call_as_jump");
        check("nostack_usp", usp, 0);
        run_op(SEQ_RET, 8'h00, 0, 0, 8'h00, 1, 8'd4, 6'd0, 1'b0, "ret_as_endi_irq");
        run_op(SEQ_RET, 8'h00, 0, 0, 8'h00, 0, 8'd2, 6'd0, 1'b0, "ret_as_endi");
        check("nostack_err", ustack_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
